// File: rtl/seq_pkg.sv
// Shared encodings for the datapath sequencer: instruction fields, opcodes,
// FSM states and the decoded-instruction bundle.
package seq_pkg;

   localparam int INSTR_W = 16;
   localparam int IDX_W   = 3;

   localparam int OPC_HI = 15, OPC_LO = 13;
   localparam int OP_HI  = 12, OP_LO  = 11;
   localparam int RN_HI  = 10, RN_LO  = 8;
   localparam int RD_HI  = 7,  RD_LO  = 5;
   localparam int SH_HI  = 4,  SH_LO  = 3;
   localparam int RM_HI  = 2,  RM_LO  = 0;
   localparam int IMM_HI = 7,  IMM_LO = 0;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_CMP    = 2'b01;
   localparam logic [1:0] OP_AND    = 2'b10;
   localparam logic [1:0] OP_MVN    = 2'b11;
   localparam logic [1:0] OP_MOVIMM = 2'b10;
   localparam logic [1:0] OP_MOVREG = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_WRIMM,
      S_GETA,
      S_GETB,
      S_EXEC,
      S_WRC,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] rn;
      logic [IDX_W-1:0] rd;
      logic [IDX_W-1:0] rm;
      logic [1:0]       op;
      logic [1:0]       sh;
      logic             is_movimm;
      logic             is_movreg;
      logic             is_alu;
      logic             is_cmp;
      logic             is_mvn;
      logic             illegal;
   } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational decode of the latched instruction word into register
// fields, class flags and the sign-extended 8-bit immediate.
module instr_decoder
   import seq_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [INSTR_W-1:0] ir,
   output dec_t               dec,
   output logic [DATA_W-1:0]  sximm8
);

   logic [2:0] opcode;
   logic [1:0] op;
   logic       is_mov_grp;
   logic       is_alu_grp;

   assign opcode     = ir[OPC_HI:OPC_LO];
   assign op         = ir[OP_HI:OP_LO];
   assign is_mov_grp = (opcode == OPC_MOV);
   assign is_alu_grp = (opcode == OPC_ALU);

   assign dec.rn        = ir[RN_HI:RN_LO];
   assign dec.rd        = ir[RD_HI:RD_LO];
   assign dec.rm        = ir[RM_HI:RM_LO];
   assign dec.op        = op;
   assign dec.sh        = ir[SH_HI:SH_LO];
   assign dec.is_movimm = is_mov_grp && (op == OP_MOVIMM);
   assign dec.is_movreg = is_mov_grp && (op == OP_MOVREG);
   assign dec.is_alu    = is_alu_grp;
   assign dec.is_cmp    = is_alu_grp && (op == OP_CMP);
   assign dec.is_mvn    = is_alu_grp && (op == OP_MVN);
   // MOV with op 01/11 and every other opcode fall through to illegal.
   assign dec.illegal   = !(dec.is_movimm || dec.is_movreg || is_alu_grp);

   assign sximm8 = {{(DATA_W-8){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle Moore controller that walks the register-file/ALU datapath
// through one instruction per start/ready handshake.
module datapath_sequencer
   import seq_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [INSTR_W-1:0]  instr,
   output logic                ready,
   output logic                done,
   output logic                err,
   output logic [REG_W-1:0]    readnum,
   output logic [REG_W-1:0]    writenum,
   output logic                write,
   output logic                vsel,
   output logic                loada,
   output logic                loadb,
   output logic                asel,
   output logic                bsel,
   output logic [1:0]          shift,
   output logic [1:0]          ALUop,
   output logic                loadc,
   output logic                loads,
   output logic [DATA_W-1:0]   datapath_in
);

   state_t               state, state_nxt;
   logic [INSTR_W-1:0]   ir;
   logic [REG_W-1:0]     readnum_q, writenum_q;
   dec_t                 dec;

   instr_decoder #(.DATA_W(DATA_W)) u_dec (
      .ir     (ir),
      .dec    (dec),
      .sximm8 (datapath_in)
   );

   // Register indices keep their last driven value between the states
   // that drive them, so they are echoed back through a holding register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         ir         <= '0;
         readnum_q  <= '0;
         writenum_q <= '0;
      end else begin
         state      <= state_nxt;
         readnum_q  <= readnum;
         writenum_q <= writenum;
         if (state == S_IDLE && start)
            ir <= instr;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      readnum   = readnum_q;
      writenum  = writenum_q;
      write     = 1'b0;
      vsel      = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      shift     = 2'b00;
      ALUop     = 2'b00;
      loadc     = 1'b0;
      loads     = 1'b0;

      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start)
               state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (dec.illegal)
               state_nxt = S_DONE;
            else if (dec.is_movimm)
               state_nxt = S_WRIMM;
            else if (dec.is_movreg || dec.is_mvn)
               state_nxt = S_GETB;
            else
               state_nxt = S_GETA;
         end
         S_WRIMM: begin
            writenum  = dec.rn;
            vsel      = 1'b1;
            write     = 1'b1;
            state_nxt = S_DONE;
         end
         S_GETA: begin
            readnum   = dec.rn;
            loada     = 1'b1;
            state_nxt = S_GETB;
         end
         S_GETB: begin
            readnum   = dec.rm;
            loadb     = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            // Single-operand ops zero A so the ALU passes or inverts B.
            shift     = dec.sh;
            loadc     = 1'b1;
            asel      = dec.is_movreg || dec.is_mvn;
            ALUop     = dec.is_movreg ? 2'b00 : dec.op;
            loads     = dec.is_cmp;
            state_nxt = dec.is_cmp ? S_DONE : S_WRC;
         end
         S_WRC: begin
            writenum  = dec.rd;
            write     = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            err       = dec.illegal;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
